// File: rtl/cam_deserializer.sv
// Receive side of the 4-bit parallel camera link: synchronizes pclk/sync/data into clk_i,
// shifts one nibble per pclk rise while sync is high, and presents 32-bit words on valid/ready.
module cam_deserializer #(
  parameter int SYNC_STAGES = 2,
  parameter int NIBBLES     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cam_pclk,
  input  logic                   cam_sync,
  input  logic [3:0]             cam_data,
  output logic [4*NIBBLES-1:0]   data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   active_o
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_e;

  logic [5:0]    sync_d [SYNC_STAGES];
  logic [5:0]    sync_q [SYNC_STAGES];
  logic          pclk_prev_d, pclk_prev_q;
  state_e        state_d, state_q;
  logic [W-1:0]  shift_d, shift_q;
  logic [CW-1:0] count_d, count_q;
  logic [FW-1:0] fill_d, fill_q;
  logic [W-1:0]  data_d, data_q;
  logic          valid_d, valid_q;
  logic          ferr_d, ferr_q;
  logic          ovr_d, ovr_q;
  logic          active_d, active_q;

  logic          s_pclk, s_sync, pclk_rise, capture, complete;
  logic [3:0]    s_data;
  logic [W-1:0]  base_shift, word;
  logic [CW-1:0] base_count;

  // All six link bits share one chain so sync/data stay aligned with pclk.
  always_comb begin
    sync_d[0] = {cam_pclk, cam_sync, cam_data};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign s_pclk      = sync_q[SYNC_STAGES-1][5];
  assign s_sync      = sync_q[SYNC_STAGES-1][4];
  assign s_data      = sync_q[SYNC_STAGES-1][3:0];
  assign pclk_rise   = s_pclk & ~pclk_prev_q;
  assign pclk_prev_d = s_pclk;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    fill_d     = fill_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    base_shift = shift_q;
    base_count = count_q;
    word       = '0;

    case (state_q)
      // Wait for the cleared chain to refill before trusting s_sync, so a
      // reset in mid-frame does not re-enter that frame.
      WAIT_IDLE: begin
        if (fill_q != FW'(SYNC_STAGES)) fill_d = fill_q + FW'(1);
        else if (!s_sync)               state_d = IDLE;
      end
      IDLE: begin
        if (s_sync) begin
          state_d    = ACTIVE;
          base_shift = '0;
          base_count = '0;
          shift_d    = '0;
          count_d    = '0;
          capture    = pclk_rise;
        end
      end
      ACTIVE: begin
        capture = pclk_rise;
        if (!s_sync) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (capture) begin
      word    = {s_data, base_shift[W-1:4]};
      shift_d = word;
      if (base_count == CW'(NIBBLES - 1)) begin
        complete = 1'b1;
        count_d  = '0;
      end else begin
        count_d  = base_count + CW'(1);
      end
    end

    // Frame end: a nibble landing in the same cycle still counts, so only a
    // genuinely partial word is flagged.
    if (state_q == ACTIVE && !s_sync) begin
      if (count_d != '0) ferr_d = 1'b1;
      count_d = '0;
    end

    if (complete) begin
      if (!valid_q || ready_i) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      pclk_prev_q <= 1'b0;
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      fill_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      pclk_prev_q <= pclk_prev_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      active_q    <= active_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign active_o    = active_q;

endmodule
